// File: rtl/hw_job_sequencer_pkg.sv
// Shared definitions for the hardware job sequencer.
// Register addresses and the per-slot state encoding.
package hw_job_sequencer_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_DONE  = 2'd1;
    localparam logic [1:0] REG_ERR   = 2'd2;
    localparam logic [1:0] REG_IRQEN = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN
    } slot_state_e;

endpackage

// File: rtl/hw_job_slot.sv
// One engine slot: launch/run FSM, timeout counter,
// and the sticky DONE/ERR flags for that engine.
module hw_job_slot
    import hw_job_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic launch,
    input  logic clr_done,
    input  logic clr_err,
    input  logic done,
    output logic start,
    output logic busy,
    output logic done_flag,
    output logic err_flag
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    slot_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Flag sets are assigned after the W1C clear so a set wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q & ~clr_done;
        err_d   = err_q & ~clr_err;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = LAUNCH;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LAUNCH: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                if (done) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign start     = (state_q == LAUNCH);
    assign busy      = (state_q != IDLE);
    assign done_flag = done_q;
    assign err_flag  = err_q;

endmodule

// File: rtl/hw_job_sequencer.sv
// Avalon-MM front end for N_ENG job slots: register decode,
// IRQ enable, registered read mux and level interrupt.
module hw_job_sequencer
    import hw_job_sequencer_pkg::*;
#(
    parameter int N_ENG   = 8,
    parameter int TIMEOUT = 1048576
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic             read,
    output logic [31:0]      readdata,
    output logic [N_ENG-1:0] start,
    input  logic [N_ENG-1:0] done,
    output logic [N_ENG-1:0] done_status,
    output logic             irq
);

    logic [N_ENG-1:0] launch_v;
    logic [N_ENG-1:0] clr_done_v;
    logic [N_ENG-1:0] clr_err_v;
    logic [N_ENG-1:0] busy_v;
    logic [N_ENG-1:0] done_v;
    logic [N_ENG-1:0] err_v;
    logic [N_ENG-1:0] wd_eng;

    logic        irqen_q, irqen_d;
    logic [31:0] readdata_q, readdata_d;
    logic        unused_wd;

    assign wd_eng     = writedata[N_ENG-1:0];
    assign launch_v   = (write && address == REG_CTRL) ? wd_eng : '0;
    assign clr_done_v = (write && address == REG_DONE) ? wd_eng : '0;
    assign clr_err_v  = (write && address == REG_ERR)  ? wd_eng : '0;
    assign unused_wd  = ^writedata;

    for (genvar g = 0; g < N_ENG; g++) begin : g_slot
        hw_job_slot #(
            .TIMEOUT (TIMEOUT)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .launch    (launch_v[g]),
            .clr_done  (clr_done_v[g]),
            .clr_err   (clr_err_v[g]),
            .done      (done[g]),
            .start     (start[g]),
            .busy      (busy_v[g]),
            .done_flag (done_v[g]),
            .err_flag  (err_v[g])
        );
    end

    always_comb begin
        irqen_d = irqen_q;
        if (write && address == REG_IRQEN) begin
            irqen_d = writedata[0];
        end
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            REG_CTRL:  readdata_d[N_ENG-1:0] = busy_v;
            REG_DONE:  readdata_d[N_ENG-1:0] = done_v;
            REG_ERR:   readdata_d[N_ENG-1:0] = err_v;
            REG_IRQEN: readdata_d[0]         = irqen_q;
        endcase
    end

    // Read data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqen_q    <= 1'b0;
            readdata_q <= '0;
        end else begin
            irqen_q <= irqen_d;
            if (read) begin
                readdata_q <= readdata_d;
            end
        end
    end

    assign readdata    = readdata_q;
    assign done_status = done_v;
    assign irq         = irqen_q & ((|done_v) | (|err_v));

endmodule

// File: tb/tb_hw_job_sequencer.sv
// Directed bench for hw_job_sequencer with TIMEOUT=16:
// register vector table plus hand-written timing sequences.
module tb_hw_job_sequencer;

    localparam int N = 8;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic [N-1:0] start;
    logic [N-1:0] done;
    logic [N-1:0] done_status;
    logic        irq;

    int n_chk = 0;
    int n_pass = 0;

    hw_job_sequencer #(
        .N_ENG   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .read        (read),
        .readdata    (readdata),
        .start       (start),
        .done        (done),
        .done_status (done_status),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_w;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic pulse_done(input logic [N-1:0] v);
        done = v;
        tick();
        done = '0;
    endtask

    vec_t        vt[8];
    logic [31:0] r;
    logic [N-1:0] acc;

    initial begin
        reset     = 1'b1;
        address   = '0;
        write     = 1'b0;
        writedata = '0;
        read      = 1'b0;
        done      = '0;

        // Reset
        repeat (3) tick();
        reset = 1'b0;
        check("rst_start", 32'(start), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_done_status", 32'(done_status), 0);
        check("rst_readdata", readdata, 0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), r);
            check($sformatf("rst_reg%0d", i), r, 0);
        end

        // Register read/write vectors
        vt[0] = '{1'b1, 2'd3, 32'h0000_0001, 2'd3, 32'h1};
        vt[1] = '{1'b1, 2'd3, 32'hFFFF_FFFE, 2'd3, 32'h0};
        vt[2] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h1};
        vt[3] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0};
        vt[4] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0};
        vt[5] = '{1'b0, 2'd0, 32'h0,         2'd3, 32'h1};
        vt[6] = '{1'b1, 2'd3, 32'h0000_0000, 2'd3, 32'h0};
        vt[7] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0};
        foreach (vt[i]) begin
            if (vt[i].do_w) wr(vt[i].wa, vt[i].wd);
            rd(vt[i].ra, r);
            check($sformatf("vec%0d", i), r, vt[i].exp);
        end

        // Basic job: launch 0 and 2, finish 2
        wr(2'd0, 32'h05);
        check("basic_start", 32'(start), 32'h05);
        rd(2'd0, r);
        check("basic_start_gone", 32'(start), 0);
        check("basic_busy", r, 32'h05);
        repeat (8) tick();
        pulse_done(8'h04);
        check("basic_done_status", 32'(done_status), 32'h04);
        check("basic_irq_off", 32'(irq), 0);
        rd(2'd0, r);
        check("basic_busy_after", r, 32'h01);
        wr(2'd3, 32'h1);
        check("basic_irq_on", 32'(irq), 1);
        wr(2'd1, 32'h04);
        check("basic_clr_status", 32'(done_status), 0);
        check("basic_irq_clr", 32'(irq), 0);
        repeat (5) tick();
        rd(2'd2, r);
        check("basic_slot0_err", r, 32'h01);
        check("basic_irq_err", 32'(irq), 1);
        wr(2'd2, 32'h01);
        check("basic_err_clr_irq", 32'(irq), 0);

        // Timeout: ERR visible after edge e+17
        wr(2'd0, 32'h01);
        repeat (16) tick();
        check("tmo_early", 32'(irq), 0);
        tick();
        check("tmo_irq", 32'(irq), 1);
        rd(2'd2, r);
        check("tmo_err", r, 32'h01);
        rd(2'd0, r);
        check("tmo_busy", r, 0);
        wr(2'd2, 32'h01);

        // done on the final RUN cycle beats timeout
        wr(2'd0, 32'h01);
        repeat (16) tick();
        pulse_done(8'h01);
        check("last_done_status", 32'(done_status), 32'h01);
        rd(2'd2, r);
        check("last_err", r, 0);
        rd(2'd1, r);
        check("last_done", r, 32'h01);
        wr(2'd1, 32'h01);

        // Relaunch while busy is ignored
        wr(2'd0, 32'h01);
        check("relaunch_first", 32'(start), 32'h01);
        repeat (6) tick();
        wr(2'd0, 32'h01);
        acc = start;
        for (int i = 0; i < 9; i++) begin
            tick();
            acc |= start;
        end
        check("relaunch_no_start", 32'(acc), 0);
        check("relaunch_no_err_yet", 32'(irq), 0);
        tick();
        check("relaunch_tmo_kept", 32'(irq), 1);
        wr(2'd2, 32'h01);

        // done[3] and DONE W1C of bit 3 together: set wins
        wr(2'd0, 32'h08);
        tick();
        address   = 2'd1;
        writedata = 32'h08;
        write     = 1'b1;
        done      = 8'h08;
        tick();
        write     = 1'b0;
        done      = '0;
        check("sim_set_wins", 32'(done_status), 32'h08);
        wr(2'd1, 32'h08);
        check("sim_cleared", 32'(done_status), 0);

        // done during LAUNCH is ignored
        wr(2'd0, 32'h02);
        pulse_done(8'h02);
        check("launch_done_ign", 32'(done_status), 0);
        rd(2'd0, r);
        check("launch_still_busy", r, 32'h02);
        pulse_done(8'h02);
        check("launch_then_done", 32'(done_status), 32'h02);
        wr(2'd1, 32'hFF);

        // Reset mid-RUN
        wr(2'd0, 32'hFF);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_start", 32'(start), 0);
        check("mid_rst_status", 32'(done_status), 0);
        check("mid_rst_irq", 32'(irq), 0);
        tick();
        reset = 1'b0;
        acc = '0;
        for (int i = 0; i < TMO + 4; i++) begin
            tick();
            acc |= start;
        end
        check("mid_rst_no_start", 32'(acc), 0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), r);
            check($sformatf("mid_rst_reg%0d", i), r, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
